// File: rtl/param_universal_shift_register_if.sv
// Command/status bundle for the universal shift register: commands flow
// from the controlling master, data and handshake status flow back.
interface param_universal_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             load;
    logic             start;
    logic [1:0]       mode;
    logic             dir;
    logic [CNT_W-1:0] shift_amt;
    logic             serial_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output load, start, mode, dir, shift_amt, serial_in, data_in,
        input  data_out, serial_out, busy, done
    );

    modport slave (
        input  load, start, mode, dir, shift_amt, serial_in, data_in,
        output data_out, serial_out, busy, done
    );
endinterface

// File: rtl/param_universal_shift_register.sv
// Parallel-load shift register running multi-step logical/rotate/arithmetic
// sequences left or right, with a busy/done handshake around each sequence.
module param_universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    param_universal_shift_register_if.slave bus
);
    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ROT = 2'b01;
    localparam logic [1:0] MODE_ARI = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    // One step of the latched operation; reserved mode leaves everything as is.
    always_comb begin
        step_data = data_q;
        step_bit  = sout_q;
        case (mode_q)
            MODE_LOG, MODE_ARI: begin
                if (!dir_q) begin
                    step_data = {data_q[WIDTH-2:0], bus.serial_in};
                    step_bit  = data_q[WIDTH-1];
                end else begin
                    step_data = {(mode_q == MODE_ARI) ? data_q[WIDTH-1] : bus.serial_in,
                                 data_q[WIDTH-1:1]};
                    step_bit  = data_q[0];
                end
            end
            MODE_ROT: begin
                if (!dir_q) begin
                    step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    step_bit  = data_q[WIDTH-1];
                end else begin
                    step_data = {data_q[0], data_q[WIDTH-1:1]};
                    step_bit  = data_q[0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        data_d  = data_q;
        sout_d  = sout_q;
        case (state_q)
            ST_SHIFT: begin
                data_d = step_data;
                sout_d = step_bit;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            default: begin
                // DONE falls back to IDLE unless a new command arrives,
                // which keeps the done pulse to a single cycle.
                state_d = ST_IDLE;
                if (bus.load) begin
                    data_d = bus.data_in;
                end else if (bus.start) begin
                    if (bus.shift_amt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                        mode_d  = bus.mode;
                        dir_d   = bus.dir;
                        cnt_d   = (bus.shift_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH)
                                                                  : bus.shift_amt;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.serial_out = sout_q;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed-vector bench for param_universal_shift_register (WIDTH=8).
module tb_param_universal_shift_register;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    param_universal_shift_register_if #(.WIDTH(8)) bus ();

    param_universal_shift_register #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load    = 1'b1;
        bus.data_in = v;
        tick();
        bus.load    = 1'b0;
    endtask

    // Launch a sequence, count busy cycles, and return the observed results.
    task automatic run_seq(input logic [1:0] m, input logic d, input logic [3:0] amt,
                           input logic sin, output int nbusy, output logic done_seen);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.dir       = d;
        bus.shift_amt = amt;
        bus.serial_in = sin;
        tick();
        bus.start = 1'b0;
        nbusy = 0;
        while (bus.busy === 1'b1 && nbusy < 50) begin
            nbusy++;
            tick();
        end
        done_seen = bus.done;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.serial_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: data=%h busy=%b done=%b sout=%b, want 00 0 0 0",
                     bus.data_out, bus.busy, bus.done, bus.serial_out);
        end
        tick();
        reset = 1'b0;
        tick();
        do_load(8'h01);
        checks++;
        if (bus.data_out !== 8'h01 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL load_01: data=%h busy=%b done=%b, want 01 0 0", bus.data_out, bus.busy, bus.done);
        end
        // async reset with no clock edge in between
        reset = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.serial_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: data=%h busy=%b done=%b sout=%b, want 00 0 0 0",
                     bus.data_out, bus.busy, bus.done, bus.serial_out);
        end
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_logical_left();
        int n;
        logic dn;
        do_load(8'h81);
        run_seq(2'b00, 1'b0, 4'd3, 1'b1, n, dn);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL lsl_busy_cycles: got %0d want 3", n);
        end
        checks++;
        if (bus.data_out !== 8'h0F || bus.serial_out !== 1'b0 || dn !== 1'b1) begin
            errors++;
            $display("FAIL lsl_result: data=%h sout=%b done=%b, want 0f 0 1", bus.data_out, bus.serial_out, dn);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL lsl_done_pulse: done=%b after one cycle, want 0", bus.done);
        end
    endtask

    task automatic test_rotate();
        int n;
        logic dn;
        do_load(8'h81);
        run_seq(2'b01, 1'b1, 4'd1, 1'b0, n, dn);
        checks++;
        if (bus.data_out !== 8'hC0 || bus.serial_out !== 1'b1 || n !== 1 || dn !== 1'b1) begin
            errors++;
            $display("FAIL ror1: data=%h sout=%b busy=%0d done=%b, want c0 1 1 1",
                     bus.data_out, bus.serial_out, n, dn);
        end
        do_load(8'h81);
        run_seq(2'b01, 1'b1, 4'd8, 1'b0, n, dn);
        checks++;
        if (bus.data_out !== 8'h81 || bus.serial_out !== 1'b1 || n !== 8) begin
            errors++;
            $display("FAIL ror8: data=%h sout=%b busy=%0d, want 81 1 8", bus.data_out, bus.serial_out, n);
        end
        do_load(8'h81);
        run_seq(2'b01, 1'b0, 4'd2, 1'b0, n, dn);
        checks++;
        if (bus.data_out !== 8'h06 || bus.serial_out !== 1'b0) begin
            errors++;
            $display("FAIL rol2: data=%h sout=%b, want 06 0", bus.data_out, bus.serial_out);
        end
    endtask

    task automatic test_arith();
        int n;
        logic dn;
        do_load(8'h90);
        run_seq(2'b10, 1'b1, 4'd2, 1'b0, n, dn);
        checks++;
        if (bus.data_out !== 8'hE4 || bus.serial_out !== 1'b0 || n !== 2) begin
            errors++;
            $display("FAIL asr2: data=%h sout=%b busy=%0d, want e4 0 2", bus.data_out, bus.serial_out, n);
        end
        do_load(8'h0F);
        run_seq(2'b11, 1'b0, 4'd2, 1'b1, n, dn);
        checks++;
        if (bus.data_out !== 8'h0F || n !== 2 || dn !== 1'b1) begin
            errors++;
            $display("FAIL reserved_hold: data=%h busy=%0d done=%b, want 0f 2 1", bus.data_out, n, dn);
        end
    endtask

    task automatic test_zero_and_clamp();
        int n;
        logic dn;
        do_load(8'h3C);
        run_seq(2'b00, 1'b0, 4'd0, 1'b1, n, dn);
        checks++;
        if (n !== 0 || dn !== 1'b1 || bus.data_out !== 8'h3C) begin
            errors++;
            $display("FAIL zero_amt: busy=%0d done=%b data=%h, want 0 1 3c", n, dn, bus.data_out);
        end
        do_load(8'hFF);
        run_seq(2'b00, 1'b1, 4'd12, 1'b0, n, dn);
        checks++;
        if (n !== 8 || bus.data_out !== 8'h00 || bus.serial_out !== 1'b1 || dn !== 1'b1) begin
            errors++;
            $display("FAIL clamp12: busy=%0d data=%h sout=%b done=%b, want 8 00 1 1",
                     n, bus.data_out, bus.serial_out, dn);
        end
    endtask

    task automatic test_busy_ignore();
        do_load(8'h01);
        bus.start = 1'b1; bus.mode = 2'b00; bus.dir = 1'b0;
        bus.shift_amt = 4'd3; bus.serial_in = 1'b0;
        tick();
        bus.start = 1'b0;
        // disturb every command input while the sequence runs
        bus.load = 1'b1; bus.data_in = 8'h55;
        bus.mode = 2'b01; bus.dir = 1'b1; bus.shift_amt = 4'd1;
        tick();
        tick();
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.data_out !== 8'h08 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL load_ignored: data=%h done=%b, want 08 1", bus.data_out, bus.done);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        do_load(8'hA5);
        bus.start = 1'b1; bus.mode = 2'b01; bus.dir = 1'b0; bus.shift_amt = 4'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_now: data=%h busy=%b done=%b, want 00 0 0", bus.data_out, bus.busy, bus.done);
        end
        #1;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: busy/done seen=%b, want 0", saw_done);
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.start = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0;
        bus.shift_amt = '0; bus.serial_in = 1'b0; bus.data_in = '0;
        test_reset();
        test_logical_left();
        test_rotate();
        test_arith();
        test_zero_and_clamp();
        test_busy_ignore();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_universal_shift_register.md
Name: param_universal_shift_register

Overview:
Parametrised successor to the team's basic load/shift register. It adds parallel load, multi-step shift sequences of programmable length, and left/right direction. Shift modes are logical, rotate and arithmetic, with serial in/out ports. A busy/done handshake lets a controlling FSM or serialiser launch a sequence and wait for completion.

Parameters:
WIDTH, 8, data register width in bits (>= 2).
CNT_W, $clog2(WIDTH+1) (4 for WIDTH=8), width of shift_amt and the internal step counter.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
load  in  1  parallel load request; sampled only when not busy.
start  in  1  launch a shift sequence; sampled only when not busy.
mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (hold).
dir  in  1  0 = shift left (toward MSB), 1 = shift right.
shift_amt  in  CNT_W  number of single-bit steps in the sequence.
serial_in  in  1  fill bit for logical shifts.
data_in  in  WIDTH  parallel load value.
data_out  out  WIDTH  register contents.
serial_out  out  1  last bit shifted out.
busy  out  1  high while a sequence is executing.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate, no clock required):
  - data_out = 0, serial_out = 0, busy = 0, done = 0.
  - FSM goes to IDLE; counter = 0.
- FSM states: IDLE, SHIFT, DONE.
  - busy = 1 only in SHIFT.
  - done = 1 only in DONE. All outputs are registered.
- IDLE / DONE, command acceptance:
  - DONE accepts commands exactly like IDLE.
  - load=1: data_out <= data_in at the next edge; next state IDLE. load has priority over start when both are high.
  - start=1, shift_amt=0: next state DONE; data unchanged.
  - start=1, shift_amt>0: latch mode, dir and min(shift_amt, WIDTH) into internal registers; next state SHIFT.
  - No command: next state IDLE, so done lasts exactly one cycle.
- SHIFT:
  - One step per clock using the latched mode/dir.
  - serial_in is sampled live at each step edge.
  - Counter decrements each step. The step at which the counter reaches 0 moves the FSM to DONE.
  - load and start are ignored; the mode/dir/shift_amt inputs may change freely mid-sequence.
- Latency: start at edge k with N>0 steps gives busy high for cycles k+1..k+N and done high for cycle k+N+1. With N=0, done is high for cycle k+1 and busy never rises.
- Step rules (d = data_out):
  - Logical left: {d[W-2:0], serial_in}. Logical right: {serial_in, d[W-1:1]}.
  - Rotate left: {d[W-2:0], d[W-1]}. Rotate right: {d[0], d[W-1:1]}. serial_in is ignored.
  - Arithmetic right: {d[W-1], d[W-1:1]}. Arithmetic left is identical to logical left.
  - Mode 11: data held, counter still runs, done still pulses.
- serial_out:
  - Updated on every step to the bit leaving the register: d[W-1] for left, d[0] for right. For rotate this is the wrapped bit.
  - Holds its value otherwise; not changed by load.
- Boundaries:
  - shift_amt > WIDTH is clamped to WIDTH, so a full rotate returns the original value.
  - Reset asserted mid-sequence aborts immediately; no done pulse is produced.

Test Plan:
1. Reset, then release reset, then load=1 with data_in=0x01 → data_out=0x01, busy=0, done=0; with reset=1 and no clock edge, all outputs read 0.
2. Load 0x81; start, mode=00, dir=0, amt=3, serial_in=1 → busy high 3 cycles, data_out=0x0F, serial_out=0, done high exactly 1 cycle after busy falls.
3. Load 0x81; rotate right, amt=1 → 0xC0, serial_out=1. Repeat from 0x81 with amt=8 → 0x81.
4. Load 0x90; arithmetic right, amt=2 → 0xE4, serial_out=0.
5. start with amt=0 → done pulse the next cycle, busy never high, data unchanged. Then load 0xFF; logical right, serial_in=0, amt=12 → clamped to 8, busy 8 cycles, result 0x00.
6. Pulse load=1 with data_in=0x55 while busy → ignored. Assert reset at step 2 of a 5-step sequence → data_out=0 and busy=0 immediately, no done pulse.
